imem_read_arbiter: RTL and testbench
====================================

Name: imem_read_arbiter

Overview:
- Shares the single-port, 1-cycle-latency instruction ROM between two read masters: the core fetch port (IF) and a debug/loader read port (DBG).
- Drives the ROM's select, read-enable and byte-address inputs.
- Routes the registered ROM data back to the master that issued the read, one cycle later.
- Sits between the core/debug logic and the ROM on the instruction-side AHB slice. Fetch has priority; a streak counter bounds how long debug can be starved.

Parameters:
- STARVE_LIMIT, 4: max consecutive IF grants while dbg_req is held before DBG is forced. Legal range 1..15.
- ROM_WORDS, 256: ROM depth in 32-bit words. Used only for the range check under the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- dbg_req  in  1  debug read request
- dbg_addr  in  32  debug byte address
- dbg_gnt  out  1  debug request accepted this cycle (combinational)
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  32  debug read data
- rom_sel  out  1  ROM slave select (HSEL1)
- rom_rd_en  out  1  ROM read enable
- rom_addr  out  32  ROM byte address; ROM indexes [9:2]
- rom_rdata  in  32  ROM registered output (instruction)
- busy  out  1  a granted read's data is due next cycle

Behaviour:
- Reset (reset=1 at posedge):
  - resp_valid=0, resp_owner=IF, streak=0.
  - All gnt and rvalid outputs are forced 0 combinationally while reset=1; rdata outputs are 0.
  - rom_sel=rom_rd_en=0 and rom_addr=0 while reset=1.
- Grant (combinational, in the same cycle as req):
  - dbg_gnt = dbg_req & (~if_req | streak==STARVE_LIMIT).
  - if_gnt = if_req & ~dbg_gnt.
  - At most one grant per cycle. Accepting one request per cycle gives full throughput.
- ROM drive:
  - rom_sel = rom_rd_en = if_gnt | dbg_gnt.
  - rom_addr = dbg_gnt ? dbg_addr : if_addr when granted, else 0.
- Response pipeline (registered):
  - resp_valid <= any grant; resp_owner <= DBG if dbg_gnt else IF.
  - Next cycle: if_rvalid = resp_valid & owner==IF; dbg_rvalid = resp_valid & owner==DBG.
  - Each rdata output = rom_rdata when its rvalid is high, else 32'h0.
  - busy = resp_valid.
  - Latency is exactly 1 cycle from grant to rvalid. Back-to-back grants produce back-to-back rvalids, correctly tagged.
- Starvation counter (4-bit streak):
  - if_gnt & dbg_req -> streak+1, saturating at STARVE_LIMIT.
  - dbg_gnt or ~dbg_req -> streak=0.
  - Idle cycles with dbg_req held keep streak unchanged.
- Simultaneous requests: IF wins unless streak==STARVE_LIMIT, in which case DBG wins and streak clears.
- Masters must hold req and addr until gnt; the block does not latch unaccepted requests.
- Addresses: bits [1:0] are ignored by the ROM. Addresses beyond ROM_WORDS*4 alias (wrap modulo 1 KB) unless the optional feature is enabled.
- Reset mid-operation: a response pending from the cycle before reset is dropped. No rvalid is produced in the cycle after reset deasserts, and streak restarts at 0.

Optional Feature:
- Macro: IMEM_ARB_RANGE_CHECK_EN.
- Enabled:
  - A granted request with addr[1:0]!=0 or addr>=ROM_WORDS*4 does not assert rom_sel/rom_rd_en.
  - The response cycle still asserts the owner's rvalid, with rdata=32'h0 and the owner's err output =1.
  - Extra 1-bit outputs if_err and dbg_err are added, reset 0.
- Disabled: no err ports; all granted requests access the ROM and alias as described above.

Test Plan:
- Reset: hold reset=1 with if_req=1, if_addr=0 -> if_gnt=0, rom_sel=0, all rvalid=0. Release reset -> if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=32'hfc010113.
- Streaming fetch: if_req=1, if_addr=0,4,8,... on consecutive cycles -> if_rvalid every cycle from cycle 1, rdata 32'hfc010113, 32'h02112e23, 32'h02812c23.
- Starvation: if_req=1 and dbg_req=1 continuously, STARVE_LIMIT=4 -> grant pattern IF,IF,IF,IF,DBG repeating; each dbg_rvalid one cycle after dbg_gnt.
- Tag routing: cycle0 IF addr 0x20, cycle1 DBG addr 0x88 -> cycle1 if_rvalid, rdata 32'h00200793; cycle2 dbg_rvalid, rdata 32'h0000006f; the other port's rdata stays 0.
- Reset mid-flight: grant IF at cycle N, assert reset at N+1 -> no if_rvalid at N+1 or N+2; streak=0 afterwards.
- IMEM_ARB_RANGE_CHECK_EN: dbg_addr=0x402 -> rom_sel=0; next cycle dbg_rvalid=1, dbg_err=1, dbg_rdata=0.

Source files
------------

// File: rtl/imem_read_arbiter.sv
// rtl/imem_read_arbiter.sv - fetch/debug read arbiter for the 1-cycle instruction ROM.
// Optional address range checking with err outputs: define IMEM_ARB_RANGE_CHECK_EN.
module imem_read_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ROM_WORDS    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        rom_sel,
  output logic        rom_rd_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  output logic        busy
`ifdef IMEM_ARB_RANGE_CHECK_EN
  ,
  output logic        if_err,
  output logic        dbg_err
`endif
);

  localparam logic       OWNER_IF  = 1'b0;
  localparam logic       OWNER_DBG = 1'b1;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || ROM_WORDS < 1) begin : g_param_check
    $error("imem_read_arbiter: STARVE_LIMIT must be 1..15 and ROM_WORDS >= 1");
  end

  logic        resp_valid;
  logic        resp_owner;
  logic        resp_err;
  logic [3:0]  streak;
  logic        dbg_win;
  logic        any_gnt;
  logic        range_bad;
  logic        rom_access;
  logic [31:0] req_addr;

  // Debug only wins a contended cycle once fetch has used up its streak.
  assign dbg_win  = dbg_req & (~if_req | (streak == LIMIT));
  assign dbg_gnt  = ~reset & dbg_win;
  assign if_gnt   = ~reset & if_req & ~dbg_win;
  assign any_gnt  = if_gnt | dbg_gnt;
  assign req_addr = dbg_gnt ? dbg_addr : if_addr;

`ifdef IMEM_ARB_RANGE_CHECK_EN
  localparam logic [32:0] ROM_BYTES = 33'(ROM_WORDS) * 33'd4;
  assign range_bad = (req_addr[1:0] != 2'b00) | ({1'b0, req_addr} >= ROM_BYTES);
`else
  assign range_bad = 1'b0;
`endif

  assign rom_access = any_gnt & ~range_bad;
  assign rom_sel    = rom_access;
  assign rom_rd_en  = rom_access;
  assign rom_addr   = any_gnt ? req_addr : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_owner <= OWNER_IF;
      resp_err   <= 1'b0;
      streak     <= 4'd0;
    end else begin
      resp_valid <= any_gnt;
      resp_owner <= dbg_gnt ? OWNER_DBG : OWNER_IF;
      resp_err   <= any_gnt & range_bad;
      if (dbg_gnt || !dbg_req) begin
        streak <= 4'd0;
      end else if (if_gnt && streak != LIMIT) begin
        streak <= streak + 4'd1;
      end
    end
  end

  // The ROM output is only meaningful in the cycle after an accepted, in-range read.
  assign if_rvalid  = ~reset & resp_valid & (resp_owner == OWNER_IF);
  assign dbg_rvalid = ~reset & resp_valid & (resp_owner == OWNER_DBG);
  assign if_rdata   = (if_rvalid & ~resp_err) ? rom_rdata : 32'h0;
  assign dbg_rdata  = (dbg_rvalid & ~resp_err) ? rom_rdata : 32'h0;
  assign busy       = resp_valid;

`ifdef IMEM_ARB_RANGE_CHECK_EN
  assign if_err  = if_rvalid & resp_err;
  assign dbg_err = dbg_rvalid & resp_err;
`endif

endmodule

// File: tb/tb_imem_read_arbiter.sv
// tb/tb_imem_read_arbiter.sv - scoreboard bench for imem_read_arbiter with a ROM model.
module tb_imem_read_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int ROM_WORDS    = 256;

  logic        clk;
  logic        reset;
  logic        if_req, dbg_req;
  logic [31:0] if_addr, dbg_addr;
  logic        if_gnt, dbg_gnt, if_rvalid, dbg_rvalid;
  logic [31:0] if_rdata, dbg_rdata;
  logic        rom_sel, rom_rd_en;
  logic [31:0] rom_addr, rom_rdata;
  logic        busy;
`ifdef IMEM_ARB_RANGE_CHECK_EN
  logic        if_err, dbg_err;
`endif

  imem_read_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ROM_WORDS(ROM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rom_sel(rom_sel), .rom_rd_en(rom_rd_en), .rom_addr(rom_addr),
    .rom_rdata(rom_rdata), .busy(busy)
`ifdef IMEM_ARB_RANGE_CHECK_EN
    , .if_err(if_err), .dbg_err(dbg_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h9e3779b9) ^ 32'h5a5a0000;
    mem[0]  = 32'hfc010113;
    mem[1]  = 32'h02112e23;
    mem[2]  = 32'h02812c23;
    mem[8]  = 32'h00200793;
    mem[34] = 32'h0000006f;
  end

  // ROM: registered output, one-cycle latency.
  always @(posedge clk) if (rom_rd_en) rom_rdata <= mem[rom_addr[9:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic        owner;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // Reference model: grant decision, ROM drive, expected response per accepted read.
  int m_wins = 0;
  always @(negedge clk) begin
    logic        e_dbg, e_if, bad;
    logic [31:0] a;
    if (reset) begin
      m_wins = 0;
      check("rst_if_gnt", if_gnt, 0);
      check("rst_dbg_gnt", dbg_gnt, 0);
      check("rst_rom_sel", rom_sel, 0);
      check("rst_rom_addr", rom_addr, 0);
    end else begin
      e_dbg = dbg_req && (!if_req || m_wins >= STARVE_LIMIT);
      e_if  = if_req && !e_dbg;
      a     = e_dbg ? dbg_addr : if_addr;
`ifdef IMEM_ARB_RANGE_CHECK_EN
      bad = (a % 4 != 0) || (64'(a) >= 64'(ROM_WORDS) * 4);
`else
      bad = 1'b0;
`endif
      check("if_gnt", if_gnt, e_if);
      check("dbg_gnt", dbg_gnt, e_dbg);
      check("rom_sel", rom_sel, (e_if || e_dbg) && !bad);
      check("rom_rd_en", rom_rd_en, (e_if || e_dbg) && !bad);
      check("rom_addr", rom_addr, (e_if || e_dbg) ? a : 32'h0);
      if (e_if || e_dbg)
        sb.push_back('{due: cyc + 1, owner: e_dbg, err: bad,
                       data: bad ? 32'h0 : mem[(a % 1024) / 4]});
      if (e_dbg || !dbg_req) m_wins = 0;
      else if (e_if && m_wins < STARVE_LIMIT) m_wins = m_wins + 1;
    end
  end

  // Monitor: pops the expected response due this cycle and compares the outputs.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_dbg_rvalid", dbg_rvalid, 0);
      check("rst_if_rdata", if_rdata, 0);
      sb.delete();
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("if_rvalid", if_rvalid, !e.owner);
      check("dbg_rvalid", dbg_rvalid, e.owner);
      check("if_rdata", if_rdata, e.owner ? 32'h0 : e.data);
      check("dbg_rdata", dbg_rdata, e.owner ? e.data : 32'h0);
      check("busy", busy, 1);
`ifdef IMEM_ARB_RANGE_CHECK_EN
      check("if_err", if_err, !e.owner && e.err);
      check("dbg_err", dbg_err, e.owner && e.err);
`endif
    end else begin
      check("idle_if_rvalid", if_rvalid, 0);
      check("idle_dbg_rvalid", dbg_rvalid, 0);
      check("idle_if_rdata", if_rdata, 0);
      check("idle_dbg_rdata", dbg_rdata, 0);
    end
  end

  logic ig, dg;
  task automatic tick();
    @(negedge clk);
    ig = if_gnt;
    dg = dbg_gnt;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom % 8;
    if (r < 5)      return ($urandom % 256) * 4;
    else if (r < 7) return $urandom & 32'hffff_fffc;
    else            return $urandom;
  endfunction

  initial begin
    reset = 1'b1; if_req = 1'b1; if_addr = 32'h0; dbg_req = 1'b0; dbg_addr = 32'h0;
    repeat (3) tick();
    reset = 1'b0;
    // Streaming fetch from address 0.
    for (int i = 0; i < 8; i++) begin
      tick();
      if_addr = 32'(i + 1) * 4;
    end
    // Tag routing: IF then DBG on consecutive cycles.
    if_addr = 32'h20;
    tick();
    if_req = 1'b0; dbg_req = 1'b1; dbg_addr = 32'h88;
    tick();
    dbg_req = 1'b0;
    repeat (2) tick();
    // Starvation with both masters holding requests.
    if_req = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h88; if_addr = 32'h0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ig) if_addr = if_addr + 32'h4;
      if (dg) dbg_addr = dbg_addr + 32'h4;
    end
    // Reset with a fetch response in flight and a partial streak.
    if_req = 1'b1; if_addr = 32'h10; dbg_req = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ig) if_addr = if_addr + 32'h4;
    end
`ifdef IMEM_ARB_RANGE_CHECK_EN
    if_req = 1'b0; dbg_req = 1'b1; dbg_addr = 32'h402;
    tick();
    dbg_req = 1'b0;
    tick();
`endif
    // Randomised traffic; masters hold request and address until granted.
    for (int i = 0; i < 500; i++) begin
      tick();
      if (!if_req || ig) begin
        if_req  = ($urandom % 4) != 0;
        if_addr = rand_addr();
      end
      if (!dbg_req || dg) begin
        dbg_req  = ($urandom % 3) == 0;
        dbg_addr = rand_addr();
      end
      if (($urandom % 97) == 0) reset = 1'b1;
      else reset = 1'b0;
    end
    reset = 1'b0; if_req = 1'b0; dbg_req = 1'b0;
    repeat (3) tick();
    check("drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
